// File: rtl/pdp8_mem_responder_pkg.sv
// ============================================================================
// Module   : pdp8_pkg
// Brief    : Shared constants, FSM state type and parity helper for the pdp8
//            pin-bus memory responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pdp8_pkg;
  localparam int WORD_W = 12;
  localparam int HALF_W = 6;
  localparam int BUS_REQ = 7;
  localparam int BUS_AUX = 6;
  localparam logic [7:0] WACK_BEAT = 8'h80;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WACK    = 3'd4,
    WAIT    = 3'd5,
    RESP_HI = 3'd6,
    RESP_LO = 3'd7
  } state_t;

  function automatic logic half_parity(input logic [HALF_W-1:0] h);
    return ^h;
  endfunction
endpackage

`default_nettype wire

// File: rtl/pdp8_mem_responder_if.sv
// ============================================================================
// Module   : pdp8_mem_responder_if
// Brief    : Chip pin bus: bus_out is the chip's uo_out, bus_in its ui_in.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pdp8_mem_responder_if;
  logic [7:0] bus_out;
  logic [7:0] bus_in;

  modport master (output bus_out, input bus_in);
  modport slave (input bus_out, output bus_in);
endinterface

`default_nettype wire

// File: rtl/pdp8_mem_array.sv
// ============================================================================
// Module   : pdp8_mem_array
// Brief    : Single-port 2^ADDR_W x 12 synchronous RAM with registered read;
//            the write port is shared by the bus and the preload strobe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pdp8_mem_array
  import pdp8_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [WORD_W-1:0] bus_wdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;
  logic [ADDR_W-1:0] w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic              w_we;

  // Bus access wins the single port; the top only raises ld_we when idle.
  assign w_we    = bus_we | ld_we;
  assign w_addr  = (bus_we | bus_re) ? bus_addr : ld_addr;
  assign w_wdata = bus_we ? bus_wdata : ld_data;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
    if (bus_re) begin
      r_rdata <= r_mem[w_addr];
    end
  end

  assign rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/pdp8_mem_responder.sv
// ============================================================================
// Module   : pdp8_mem_responder
// Brief    : Memory-side responder for the pdp8 pin bus. Optional beat parity
//            is enabled by defining PDP8_BUS_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pdp8_mem_responder
  import pdp8_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pdp8_mem_responder_if.slave   bus,
  input  logic                  ld_we,
  input  logic [WORD_W-1:0]     ld_addr,
  input  logic [WORD_W-1:0]     ld_data,
  output logic                  busy,
  output logic                  err
);
  localparam int RD_LAT_C = (RD_LAT < 1) ? 1 : RD_LAT;
  localparam int CNT_W    = $clog2(RD_LAT_C + 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [HALF_W-1:0]   r_addr_hi;
  logic [WORD_W-1:0]   r_addr;
  logic [HALF_W-1:0]   r_data_hi;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_bus_in;
  logic                r_err;
  logic [7:0]          w_bus_in_next;
  logic                w_abort;
  logic                w_mem_we;
  logic                w_mem_re;
  logic                w_req;
  logic                w_par_ok;
  logic                w_par_hi;
  logic                w_par_lo;
  logic                w_ld_we;
  logic [WORD_W-1:0]   w_req_addr;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [WORD_W-1:0]   w_rdata;
  logic                w_unused;

  assign w_req      = bus.bus_out[BUS_REQ];
  assign w_req_addr = {r_addr_hi, bus.bus_out[HALF_W-1:0]};
  assign w_mem_addr = (r_state == DATA_LO) ? r_addr[ADDR_W-1:0] : w_req_addr[ADDR_W-1:0];
  assign w_ld_we    = ld_we && (r_state == IDLE) && !w_req;
  assign w_unused   = ^{bus.bus_out[BUS_AUX], ld_addr, r_addr};

`ifdef PDP8_BUS_PARITY_EN
  assign w_par_ok = (bus.bus_out[BUS_AUX] == half_parity(bus.bus_out[HALF_W-1:0]));
  assign w_par_hi = half_parity(w_rdata[WORD_W-1:HALF_W]);
  assign w_par_lo = half_parity(w_rdata[HALF_W-1:0]);
`else
  assign w_par_ok = 1'b1;
  assign w_par_hi = 1'b0;
  assign w_par_lo = 1'b0;
`endif

  pdp8_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .bus_we    (w_mem_we),
    .bus_re    (w_mem_re),
    .bus_addr  (w_mem_addr),
    .bus_wdata ({r_data_hi, bus.bus_out[HALF_W-1:0]}),
    .ld_we     (w_ld_we),
    .ld_addr   (ld_addr[ADDR_W-1:0]),
    .ld_data   (ld_data),
    .rdata     (w_rdata)
  );

  always_comb begin
    w_next        = r_state;
    w_abort       = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_re      = 1'b0;
    w_bus_in_next = 8'h00;
    case (r_state)
      IDLE:    if (w_req) w_next = ADDR_LO;
      ADDR_LO: begin
        if (!(w_req && w_par_ok)) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (r_we) begin
          w_next = DATA_HI;
        end else begin
          w_mem_re = 1'b1;
          w_next   = WAIT;
        end
      end
      DATA_HI: begin
        if (w_req && w_par_ok) begin
          w_next = DATA_LO;
        end else begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      DATA_LO: begin
        if (w_req && w_par_ok) begin
          w_mem_we = 1'b1;
          w_next   = WACK;
        end else begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      WACK:    w_next = IDLE;
      WAIT:    if (r_cnt == '0) w_next = RESP_HI;
      RESP_HI: w_next = RESP_LO;
      RESP_LO: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // bus_in is registered, so decode it from the state being entered.
    case (w_next)
      WACK:    w_bus_in_next = WACK_BEAT;
      RESP_HI: w_bus_in_next = {1'b1, w_par_hi, w_rdata[WORD_W-1:HALF_W]};
      RESP_LO: w_bus_in_next = {1'b1, w_par_lo, w_rdata[HALF_W-1:0]};
      default: w_bus_in_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr_hi <= '0;
      r_addr    <= '0;
      r_data_hi <= '0;
      r_cnt     <= '0;
      r_bus_in  <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_bus_in <= w_bus_in_next;
      r_err    <= w_abort;
      if (r_state == IDLE && w_req) begin
        r_we      <= bus.bus_out[BUS_AUX];
        r_addr_hi <= bus.bus_out[HALF_W-1:0];
      end
      if (r_state == ADDR_LO) begin
        r_addr <= w_req_addr;
        r_cnt  <= CNT_W'(RD_LAT_C - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == DATA_HI) begin
        r_data_hi <= bus.bus_out[HALF_W-1:0];
      end
    end
  end

  assign bus.bus_in = r_bus_in;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;
endmodule

`default_nettype wire
